// File: rtl/befehls_holsteuerung.sv
// Instruction-fetch sequencer: owns the PC, fetches from instruction memory, presents
// each word to decode and applies jump/call/return redirects via a return-address stack.
module befehls_holsteuerung #(
  parameter int                    ADR_BREITE    = 26,
  parameter int                    DATEN_BREITE  = 32,
  parameter int                    STAPEL_TIEFE  = 8,
  parameter logic [ADR_BREITE-1:0] START_ADRESSE = '0
) (
  input  logic                    TaktSignal,
  input  logic                    Reset,
  output logic                    SpeicherAnfrage,
  output logic [ADR_BREITE-1:0]   SpeicherAdresse,
  input  logic                    SpeicherBereit,
  input  logic [DATEN_BREITE-1:0] SpeicherDaten,
  output logic [DATEN_BREITE-1:0] Befehl,
  output logic                    BefehlGueltig,
  output logic [ADR_BREITE-1:0]   BefehlPC,
  input  logic                    Stall,
  input  logic                    SprungGueltig,
  input  logic                    AufrufGueltig,
  input  logic                    RueckkehrGueltig,
  input  logic [ADR_BREITE-1:0]   SprungZiel,
  output logic                    StapelFehler
);
  localparam int ZW = $clog2(STAPEL_TIEFE + 1);
  localparam int IW = (STAPEL_TIEFE > 1) ? $clog2(STAPEL_TIEFE) : 1;

  typedef enum logic [1:0] {RUHE, ANFRAGE, AUSGABE} zustand_t;

  zustand_t              zustand, zustandNaechst;
  logic [ADR_BREITE-1:0] pc, pcNaechst;
  logic [ADR_BREITE-1:0] stapel [STAPEL_TIEFE];
  logic [ZW-1:0]         zeiger, zeigerNaechst;
  logic [IW-1:0]         schreibIdx, oberIdx;
  logic                  push, fehlerSetzen, uebernehmen;

  assign schreibIdx = IW'(zeiger);
  assign oberIdx    = IW'(zeiger - 1'b1);

  always_comb begin
    zustandNaechst = zustand;
    pcNaechst      = pc;
    zeigerNaechst  = zeiger;
    push           = 1'b0;
    fehlerSetzen   = 1'b0;
    uebernehmen    = 1'b0;
    case (zustand)
      RUHE:    zustandNaechst = ANFRAGE;
      ANFRAGE: if (SpeicherBereit) begin
        uebernehmen    = 1'b1;
        zustandNaechst = AUSGABE;
      end
      AUSGABE: if (!Stall) begin
        zustandNaechst = ANFRAGE;
        pcNaechst      = pc + 1'b1;
        if (SprungGueltig) begin
          pcNaechst = SprungZiel;
        end else if (AufrufGueltig) begin
          // a full stack loses the return address but the call target is still honoured
          pcNaechst = SprungZiel;
          if (zeiger == ZW'(STAPEL_TIEFE)) fehlerSetzen = 1'b1;
          else begin
            push          = 1'b1;
            zeigerNaechst = zeiger + 1'b1;
          end
        end else if (RueckkehrGueltig) begin
          if (zeiger == '0) fehlerSetzen = 1'b1;
          else begin
            pcNaechst     = stapel[oberIdx];
            zeigerNaechst = zeiger - 1'b1;
          end
        end
      end
      default: zustandNaechst = RUHE;
    endcase
  end

  always_ff @(posedge TaktSignal) begin
    if (!Reset) begin
      zustand      <= RUHE;
      pc           <= START_ADRESSE;
      zeiger       <= '0;
      Befehl       <= '0;
      BefehlPC     <= '0;
      StapelFehler <= 1'b0;
    end else begin
      zustand <= zustandNaechst;
      pc      <= pcNaechst;
      zeiger  <= zeigerNaechst;
      if (uebernehmen) begin
        Befehl   <= SpeicherDaten;
        BefehlPC <= pc;
      end
      if (fehlerSetzen) StapelFehler <= 1'b1;
    end
  end

  // stack storage needs no reset: the pointer alone defines which entries are live
  always_ff @(posedge TaktSignal) begin
    if (Reset && push) stapel[schreibIdx] <= pc + 1'b1;
  end

  assign SpeicherAnfrage = (zustand == ANFRAGE);
  assign BefehlGueltig   = (zustand == AUSGABE);
  assign SpeicherAdresse = pc;
endmodule

// File: tb/tb_befehls_holsteuerung.sv
// Bench for befehls_holsteuerung: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_befehls_holsteuerung;
  logic        clk = 1'b0;
  logic        Reset, SpeicherBereit, Stall, SprungGueltig, AufrufGueltig, RueckkehrGueltig;
  logic        SpeicherAnfrage, BefehlGueltig, StapelFehler;
  logic [25:0] SpeicherAdresse, BefehlPC, SprungZiel;
  logic [31:0] SpeicherDaten, Befehl;
  bit          datMode = 1'b0;

  int nChecks = 0, nPass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [25:0] a, input bit mode);
    return mode ? {a[5:0], a} : {6'b0, a};
  endfunction

  assign SpeicherDaten = SpeicherBereit ? mem(SpeicherAdresse, datMode) : 32'hDEAD_BEEF;

  befehls_holsteuerung dut (
    .TaktSignal(clk), .Reset(Reset),
    .SpeicherAnfrage(SpeicherAnfrage), .SpeicherAdresse(SpeicherAdresse),
    .SpeicherBereit(SpeicherBereit), .SpeicherDaten(SpeicherDaten),
    .Befehl(Befehl), .BefehlGueltig(BefehlGueltig), .BefehlPC(BefehlPC),
    .Stall(Stall), .SprungGueltig(SprungGueltig), .AufrufGueltig(AufrufGueltig),
    .RueckkehrGueltig(RueckkehrGueltig), .SprungZiel(SprungZiel),
    .StapelFehler(StapelFehler)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
  endtask

  // Model: a fetch is outstanding until acked, then one instruction is held until
  // decode accepts it, at which point the redirect rules pick the next address.
  logic [25:0] mPc, mBpc;
  logic [31:0] mBef;
  bit          mOn = 1'b0, mStarted, mOutstanding, mHolding, mErr;
  logic [25:0] mStack[$];

  always @(posedge clk) begin
    if (!Reset) begin
      mPc = '0; mBpc = '0; mBef = '0; mErr = 1'b0;
      mStarted = 1'b0; mOutstanding = 1'b0; mHolding = 1'b0;
      mStack.delete();
      mOn = 1'b1;
    end else if (mOn) begin
      if (!mStarted) begin
        mStarted = 1'b1; mOutstanding = 1'b1;
      end else if (mOutstanding) begin
        if (SpeicherBereit) begin
          mBef = mem(mPc, datMode); mBpc = mPc;
          mOutstanding = 1'b0; mHolding = 1'b1;
        end
      end else if (mHolding && !Stall) begin
        mHolding = 1'b0; mOutstanding = 1'b1;
        if (SprungGueltig) mPc = SprungZiel;
        else if (AufrufGueltig) begin
          if (mStack.size() < 8) mStack.push_back(mPc + 26'd1);
          else mErr = 1'b1;
          mPc = SprungZiel;
        end else if (RueckkehrGueltig) begin
          if (mStack.size() == 0) begin mErr = 1'b1; mPc = mPc + 26'd1; end
          else mPc = mStack.pop_back();
        end else mPc = mPc + 26'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (mOn) begin
      chk("anfrage", SpeicherAnfrage, mOutstanding);
      chk("gueltig", BefehlGueltig, mHolding);
      chk("befehl", Befehl, mBef);
      chk("befehlpc", BefehlPC, mBpc);
      chk("stapelfehler", StapelFehler, mErr);
      if (mOutstanding) chk("adresse", SpeicherAdresse, mPc);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!BefehlGueltig && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    Reset = 1'b0; cyc(); cyc();
    Reset = 1'b1; cyc();
  endtask

  task automatic redirect(input bit spr, input bit auf, input bit rue, input logic [25:0] z);
    SprungGueltig = spr; AufrufGueltig = auf; RueckkehrGueltig = rue; SprungZiel = z;
    cyc();
    SprungGueltig = 1'b0; AufrufGueltig = 1'b0; RueckkehrGueltig = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b0; SpeicherBereit = 1'b1; Stall = 1'b0;
    SprungGueltig = 1'b0; AufrufGueltig = 1'b0; RueckkehrGueltig = 1'b0; SprungZiel = '0;
    cyc(); cyc(); cyc();
    chk("rst_anfrage", SpeicherAnfrage, 1'b0);
    chk("rst_gueltig", BefehlGueltig, 1'b0);
    chk("rst_befehl", Befehl, 32'd0);
    chk("rst_fehler", StapelFehler, 1'b0);

    // zero-wait sequential fetch
    Reset = 1'b1; cyc();
    chk("t1_anfrage", SpeicherAnfrage, 1'b1);
    chk("t1_adr0", SpeicherAdresse, 26'd0);
    for (int i = 0; i < 3; i++) begin
      waitValid(n);
      chk("t1_latenz", n, 1);
      chk("t1_bpc", BefehlPC, i);
      chk("t1_befehl", Befehl, i);
      cyc();
      chk("t1_puls", BefehlGueltig, 1'b0);
      chk("t1_adr", SpeicherAdresse, i + 1);
    end

    // three wait states at PC=4
    waitValid(n); SpeicherBereit = 1'b0; cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_anfrage", SpeicherAnfrage, 1'b1);
      chk("t2_adr", SpeicherAdresse, 26'd4);
      chk("t2_kein_gueltig", BefehlGueltig, 1'b0);
      if (i == 3) SpeicherBereit = 1'b1;
      cyc();
    end
    chk("t2_gueltig", BefehlGueltig, 1'b1);
    chk("t2_bpc", BefehlPC, 26'd4);
    cyc();
    chk("t2_ein_puls", BefehlGueltig, 1'b0);

    // stalled jump at PC=5
    waitValid(n);
    chk("t3_bpc", BefehlPC, 26'd5);
    Stall = 1'b1; SprungGueltig = 1'b1; SprungZiel = 26'h100;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t3_gehalten", BefehlGueltig, 1'b1);
      chk("t3_bpc_gehalten", BefehlPC, 26'd5);
      chk("t3_keine_anfrage", SpeicherAnfrage, 1'b0);
    end
    Stall = 1'b0; cyc(); SprungGueltig = 1'b0;
    chk("t3_sprung", SpeicherAdresse, 26'h100);

    // call / return
    waitValid(n); redirect(1, 0, 0, 26'h10);
    waitValid(n); redirect(0, 1, 0, 26'h200);
    chk("t4_aufruf", SpeicherAdresse, 26'h200);
    waitValid(n);
    chk("t4_bpc", BefehlPC, 26'h200);
    cyc(); waitValid(n); redirect(0, 0, 1, 26'h0);
    chk("t4_rueckkehr", SpeicherAdresse, 26'h11);
    for (int k = 0; k < 9; k++) begin
      waitValid(n); redirect(0, 1, 0, 26'h300 + 26'(k * 16));
      chk("t4_tief_adr", SpeicherAdresse, 26'h300 + 26'(k * 16));
      chk("t4_tief_fehler", StapelFehler, k == 8);
    end

    // return on empty stack; jump beats call
    doReset();
    chk("t5_fehler_rst", StapelFehler, 1'b0);
    for (int i = 0; i < 10; i++) begin
      waitValid(n);
      if (BefehlPC == 26'd7) break;
      cyc();
    end
    chk("t5_bpc7", BefehlPC, 26'd7);
    redirect(0, 0, 1, 26'h0);
    chk("t5_leer_adr", SpeicherAdresse, 26'd8);
    chk("t5_leer_fehler", StapelFehler, 1'b1);
    waitValid(n); redirect(1, 1, 0, 26'h40);
    chk("t5_sprung_vor_aufruf", SpeicherAdresse, 26'h40);
    waitValid(n); redirect(0, 0, 1, 26'h0);
    chk("t5_kein_push", SpeicherAdresse, 26'h41);

    // address wrap and reset mid-wait
    waitValid(n); redirect(1, 0, 0, 26'h3FFFFFF);
    waitValid(n);
    chk("t6_bpc_max", BefehlPC, 26'h3FFFFFF);
    chk("t6_befehl_max", Befehl, 32'h03FFFFFF);
    cyc();
    chk("t6_wrap", SpeicherAdresse, 26'd0);
    waitValid(n); redirect(1, 0, 0, 26'h55);
    SpeicherBereit = 1'b0;
    chk("t6_warte_adr", SpeicherAdresse, 26'h55);
    cyc();
    chk("t6_warte", SpeicherAnfrage, 1'b1);
    Reset = 1'b0; cyc();
    chk("t6_rst_anfrage", SpeicherAnfrage, 1'b0);
    Reset = 1'b1; SpeicherBereit = 1'b1; cyc();
    chk("t6_neustart", SpeicherAdresse, 26'd0);
    chk("t6_neustart_anfrage", SpeicherAnfrage, 1'b1);

    // randomized traffic: call-heavy first half fills the stack, return-heavy second half drains it
    datMode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      Reset            = ($urandom_range(299) != 0);
      SpeicherBereit   = ($urandom_range(9) < 7);
      Stall            = ($urandom_range(9) < 3);
      SprungGueltig    = ($urandom_range(9) < 1);
      AufrufGueltig    = ($urandom_range(9) < ((i < 2000) ? 4 : 1));
      RueckkehrGueltig = ($urandom_range(9) < ((i < 2000) ? 1 : 4));
      SprungZiel       = 26'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
